// File: rtl/fwrisc_rf_wr_sched.sv
// fwrisc_rf_wr_sched: single write-port scheduler for the GPR/CSR file.
// Fixed priority trap > exec > minstret, with atomic trap-entry bursts.
module fwrisc_rf_wr_sched #(
  parameter logic [5:0] CSR_MEPC      = 6'h29,
  parameter logic [5:0] CSR_MCAUSE    = 6'h2A,
  parameter logic [5:0] CSR_MTVAL     = 6'h2B,
  parameter logic [5:0] CSR_MINSTRET  = 6'h3C,
  parameter logic [5:0] CSR_MINSTRETH = 6'h3D,
  parameter int         PEND_W        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_wr_req,
  input  logic [5:0]  ex_wr_addr,
  input  logic [31:0] ex_wr_data,
  output logic        ex_wr_ack,
  input  logic        trap_req,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  output logic        trap_ack,
  input  logic        instr_retired,
  output logic        rf_wen,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        instret_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    T_CAUSE,
    T_TVAL,
    CNT_HI
  } state_e;

  localparam logic [PEND_W-1:0] PEND_ONE = 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       cause_q, tval_q;
  logic              ovf_d;
  logic              ack_d;
  logic              wen_d;
  logic [5:0]        waddr_d;
  logic [31:0]       wdata_d;
  logic              idle_ok;
  logic              g_trap, g_ex, g_ret;

  // The trap_ack cycle is a dead cycle: trap_req is still held
  // by the requester, so nothing is granted until it drops.
  assign idle_ok = !reset && (state_q == IDLE) && !trap_ack;
  assign g_trap  = idle_ok && trap_req;
  assign g_ex    = idle_ok && !trap_req && ex_wr_req;
  assign g_ret   = idle_ok && !trap_req && !ex_wr_req
                   && (pend_q != '0);

  assign ex_wr_ack = g_ex;
  assign busy      = (state_q != IDLE) || (pend_q != '0);

  always_comb begin
    state_d = state_q;
    wen_d   = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    ack_d   = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          g_trap: begin
            wen_d   = 1'b1;
            waddr_d = CSR_MEPC;
            wdata_d = trap_epc;
            state_d = T_CAUSE;
          end
          g_ex: begin
            wen_d   = 1'b1;
            waddr_d = ex_wr_addr;
            wdata_d = ex_wr_data;
            if (ex_wr_addr == CSR_MINSTRET)
              lo_d = ex_wr_data;
            if (ex_wr_addr == CSR_MINSTRETH)
              hi_d = ex_wr_data;
          end
          g_ret: begin
            wen_d   = 1'b1;
            waddr_d = CSR_MINSTRET;
            wdata_d = lo_q + 32'd1;
            lo_d    = lo_q + 32'd1;
            if (lo_q == 32'hFFFF_FFFF)
              state_d = CNT_HI;
          end
          default: ;
        endcase
      end
      T_CAUSE: begin
        wen_d   = 1'b1;
        waddr_d = CSR_MCAUSE;
        wdata_d = cause_q;
        state_d = T_TVAL;
      end
      T_TVAL: begin
        wen_d   = 1'b1;
        waddr_d = CSR_MTVAL;
        wdata_d = tval_q;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      CNT_HI: begin
        wen_d   = 1'b1;
        waddr_d = CSR_MINSTRETH;
        wdata_d = hi_q + 32'd1;
        hi_d    = hi_q + 32'd1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    ovf_d  = instret_ovf;
    if (instr_retired && !g_ret) begin
      if (pend_q == PEND_MAX)
        ovf_d = 1'b1;
      else
        pend_d = pend_q + PEND_ONE;
    end else if (g_ret && !instr_retired) begin
      pend_d = pend_q - PEND_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
      rf_wen      <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      trap_ack    <= 1'b0;
      instret_ovf <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      rf_wen      <= wen_d;
      rf_waddr    <= waddr_d;
      rf_wdata    <= wdata_d;
      trap_ack    <= ack_d;
      instret_ovf <= ovf_d;
      if (g_trap) begin
        cause_q <= trap_cause;
        tval_q  <= trap_tval;
      end
    end
  end

endmodule
